sram_1024x32_port_ctrl: RTL and testbench



---
 rtl/sram_1024x32_port_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_1024x32_port_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1024x32_port_ctrl.sv
// sram_1024x32_port_ctrl
//   Front end for the 1024x32 single-port SRAM macro. After reset it writes zero to every
//   word. It then turns a valid/ready request stream into the macro's we/addr/din pins and
//   catches the one-cycle-late read data in a 2-entry response FIFO.
//
// Ports
//   clk, rst                   shared clock; asynchronous active-high reset
//   init_done                  high once the scrub has written every word
//   req_valid/req_ready        request handshake; req_we selects write (1) or read (0)
//   req_addr, req_din          request word address and write data
//   rsp_valid/rsp_ready        response handshake; rsp_dout is the FIFO head
//   sram_we/addr/din           driven to the macro
//   sram_dout                  read data from the macro, valid one cycle after the read
module sram_1024x32_port_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_done,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_din,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_dout,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic [0:0] {StScrub, StRun} state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   scrub_cnt_q;
   logic                    infl_q;      // a read was accepted last edge; its data is on sram_dout
   logic [1:0]              occ_q;
   logic [DATA_WIDTH-1:0]   fifo_q [2];  // entry 0 is the head

   logic       pop;
   logic       push;
   logic       acc;
   logic       rd_acc;
   logic [2:0] pend;

   assign pop       = rsp_valid && rsp_ready;
   assign push      = infl_q;
   // Slots still committed after this cycle; pop cannot underflow since it implies occ >= 1.
   assign pend      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
   assign req_ready = (state_q == StRun) && (pend <= 3'd1);
   assign acc       = req_valid && req_ready;
   assign rd_acc    = acc && !req_we;

   assign rsp_valid = (occ_q != 2'd0);
   assign rsp_dout  = fifo_q[0];

   always_comb begin
      sram_we   = 1'b1;
      sram_addr = scrub_cnt_q;
      sram_din  = '0;
      if (state_q == StRun) begin
         sram_we   = acc && req_we;
         sram_addr = req_addr;
         sram_din  = req_din;
      end
   end

   // Scrub / run sequencer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StScrub;
         scrub_cnt_q <= '0;
         init_done   <= 1'b0;
      end else begin
         case (state_q)
            StScrub: begin
               scrub_cnt_q <= scrub_cnt_q + 1'b1;
               if (scrub_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  state_q   <= StRun;
                  init_done <= 1'b1;
               end
            end
            StRun: begin
               state_q <= StRun;
            end
            default: begin
               state_q <= StScrub;
            end
         endcase
      end
   end

   // In-flight flag and response FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_q    <= 1'b0;
         occ_q     <= 2'd0;
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
      end else begin
         // A read accepted on the same edge as a push keeps the flag set.
         infl_q <= rd_acc;
         case ({push, pop})
            2'b10: begin
               if (occ_q == 2'd0) fifo_q[0] <= sram_dout;
               else               fifo_q[1] <= sram_dout;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               fifo_q[0] <= fifo_q[1];
               occ_q     <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  fifo_q[0] <= sram_dout;
               end else begin
                  fifo_q[0] <= fifo_q[1];
                  fifo_q[1] <= sram_dout;
               end
            end
            default: begin
               occ_q <= occ_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_1024x32_port_ctrl.sv
module tb_sram_1024x32_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_done;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [9:0]  req_addr;
   logic [31:0] req_din;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dout;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_1024x32_port_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_dout  (rsp_dout),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout)
   );

   // Behavioural model of the single-port macro: write on the edge, registered read.
   logic [31:0] mem [1024];
   always @(posedge clk) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks the scrub from just after reset release; returns the number of edges to init_done.
   task automatic scrub_walk(input string tag, output int edges, output int bad);
      edges = 0;
      bad   = 0;
      while (!init_done && edges < 1100) begin
         if (edges < 1024) begin
            if (sram_we !== 1'b1 || sram_addr !== edges[9:0] || sram_din !== 32'h0 ||
                req_ready !== 1'b0) bad++;
         end
         tick();
         edges++;
      end
      chk(tag, edges, 32'd1024);
   endtask

   logic [9:0]  ra;
   logic [31:0] wd;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   int          edges;
   int          bad;
   int          phase;
   int          pairs;
   int          pops;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_din   = '0;
      rsp_ready = 1'b0;
      #2;
      chk1("rst_init_done", init_done, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk ("rst_rsp_dout", rsp_dout, 32'h0);
      chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_sram_we", sram_we, 1'b1);
      chk ("rst_sram_addr", {22'h0, sram_addr}, 32'h0);
      chk ("rst_sram_din", sram_din, 32'h0);

      // Scrub with a request pending: it must be held off throughout.
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 10'h2AA;
      req_din   = 32'h12345678;
      #1;
      scrub_walk("scrub_edges", edges, bad);
      chk ("scrub_sequence_bad", bad, 32'd0);
      chk1("scrub_init_done", init_done, 1'b1);
      req_valid = 1'b0;

      // Read of the last word after scrub
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'h3FF;
      #1;
      chk1("rd3ff_ready", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk1("rd3ff_valid_early", rsp_valid, 1'b0);
      tick();
      chk1("rd3ff_valid", rsp_valid, 1'b1);
      chk ("rd3ff_data", rsp_dout, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk1("rd3ff_drained", rsp_valid, 1'b0);

      // Write then read-after-write on the next cycle
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 10'h155;
      req_din   = 32'hDEADBEEF;
      #1;
      chk1("wr155_sram_we", sram_we, 1'b1);
      tick();
      req_we = 1'b0;
      #1;
      chk1("rd155_ready", req_ready, 1'b1);
      chk1("rd155_sram_we", sram_we, 1'b0);
      tick();
      req_valid = 1'b0;
      chk1("rd155_valid_early", rsp_valid, 1'b0);
      tick();
      chk1("rd155_valid", rsp_valid, 1'b1);
      chk ("rd155_data", rsp_dout, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      tick();

      // Pre-write addr*3 to 0..15
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 10'(i);
         req_din   = 32'(i * 3);
         #1;
         if (req_ready !== 1'b1) bad++;
         tick();
      end
      chk("prewrite_stalls", bad, 32'd0);

      // 16 back-to-back reads with rsp_ready held high
      bad = 0;
      for (int c = 0; c < 18; c++) begin
         req_valid = (c < 16);
         req_we    = 1'b0;
         req_addr  = 10'(c);
         #1;
         if (c < 16 && req_ready !== 1'b1) bad++;
         if (c >= 2) begin
            chk1("stream_valid", rsp_valid, 1'b1);
            chk ("stream_data", rsp_dout, 32'((c - 2) * 3));
         end
         tick();
      end
      req_valid = 1'b0;
      chk ("stream_stalls", bad, 32'd0);
      chk1("stream_drained", rsp_valid, 1'b0);

      // Backpressure: only two reads outstanding
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'd5;
      #1;
      chk1("bp_ready0", req_ready, 1'b1);
      tick();
      req_addr = 10'd7;
      #1;
      chk1("bp_ready1", req_ready, 1'b1);
      tick();
      req_addr = 10'd9;
      #1;
      chk1("bp_ready2_stalled", req_ready, 1'b0);
      tick();
      chk1("bp_ready3_stalled", req_ready, 1'b0);
      chk1("bp_valid", rsp_valid, 1'b1);
      chk ("bp_head0", rsp_dout, 32'd15);
      rsp_ready = 1'b1;
      #1;
      chk1("bp_ready_on_pop", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk ("bp_head1", rsp_dout, 32'd21);
      tick();
      chk ("bp_head2", rsp_dout, 32'd27);
      tick();
      chk1("bp_drained", rsp_valid, 1'b0);

      // Alternating write/read pairs against a scoreboard with random backpressure
      phase = 0;
      pairs = 0;
      pops  = 0;
      ra    = 10'h200 + 10'($urandom_range(0, 15));
      wd    = $urandom;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         req_valid = 1'b1;
         req_we    = (phase == 0);
         req_addr  = ra;
         req_din   = wd;
         #1;
         if (rsp_valid && rsp_ready) begin
            chk1("rand_expected_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_v = exp_q.pop_front();
               chk("rand_rsp_data", rsp_dout, exp_v);
               pops++;
            end
         end
         if (req_ready) begin
            if (phase == 0) begin
               phase = 1;
            end else begin
               exp_q.push_back(wd);
               pairs++;
               phase = 0;
               ra    = 10'h200 + 10'($urandom_range(0, 15));
               wd    = $urandom;
            end
         end
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int d = 0; d < 8; d++) begin
         #1;
         if (rsp_valid) begin
            chk1("drain_expected_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               exp_v = exp_q.pop_front();
               chk("drain_rsp_data", rsp_dout, exp_v);
               pops++;
            end
         end
         tick();
      end
      chk ("rand_leftover", exp_q.size(), 32'd0);
      chk1("rand_drained", rsp_valid, 1'b0);
      chk ("rand_pops", pops, pairs);
      chk1("rand_progress", pairs > 150, 1'b1);

      // Reset with two responses pending
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'h155;
      tick();
      req_addr = 10'h3FF;
      tick();
      req_valid = 1'b0;
      tick();
      chk1("pre_reset_valid", rsp_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk1("mid_reset_valid", rsp_valid, 1'b0);
      chk1("mid_reset_init_done", init_done, 1'b0);
      chk1("mid_reset_ready", req_ready, 1'b0);
      chk ("mid_reset_addr", {22'h0, sram_addr}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      scrub_walk("rescrub_edges", edges, bad);
      chk("rescrub_sequence_bad", bad, 32'd0);
      rsp_ready = 1'b1;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid !== 1'b0) bad++;
         tick();
      end
      chk("no_stale_rsp", bad, 32'd0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'h155;
      tick();
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      tick();
      chk1("post_reset_rd_valid", rsp_valid, 1'b1);
      chk ("post_reset_rd_data", rsp_dout, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
